ndp_seq_ctrl: RTL and testbench

NDP_SEQ_CTRL -- requirements
Module: ndp_seq_ctrl

---
 rtl/ndp_pkg.sv | 22 ++
 rtl/ndp_seq_wdog.sv | 27 ++
 rtl/ndp_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ndp_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ndp_pkg.sv
// rtl/ndp_pkg.sv - FSM state encoding and default operand/result widths for ndp_seq_ctrl
package ndp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ARR_WIDTH  = 2;
  localparam int DEF_ARR_HEIGHT = 2;
  localparam int DEF_SYS_WIDTH  = 1;
  localparam int DEF_SYS_HEIGHT = 1;

  localparam int A_W = DEF_ARR_HEIGHT * DEF_SYS_HEIGHT * DEF_WIDTH;
  localparam int B_W = DEF_ARR_WIDTH * DEF_SYS_WIDTH * DEF_WIDTH;
  localparam int C_W = DEF_ARR_WIDTH * DEF_ARR_HEIGHT * DEF_SYS_WIDTH * DEF_SYS_HEIGHT * DEF_WIDTH;

endpackage

// File: rtl/ndp_seq_wdog.sv
// rtl/ndp_seq_wdog.sv - DRAIN-phase watchdog, counts enabled cycles and flags the last one before LIMIT
module ndp_seq_wdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = en ? cnt_q + 1'b1 : '0;
  end

  // Asserted in the LIMIT-th enabled cycle so the FSM leaves exactly LIMIT cycles after entry.
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ndp_seq_ctrl.sv
// rtl/ndp_seq_ctrl.sv - sequencer streaming operand vectors from memory into an NDPUnit and capturing its result
// Optional DRAIN watchdog enabled by defining NDP_SEQ_TIMEOUT_EN.
module ndp_seq_ctrl
  import ndp_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ARR_WIDTH   = DEF_ARR_WIDTH,
  parameter int ARR_HEIGHT  = DEF_ARR_HEIGHT,
  parameter int SYS_WIDTH   = DEF_SYS_WIDTH,
  parameter int SYS_HEIGHT  = DEF_SYS_HEIGHT,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic [ADDR_W-1:0]                                      k_len,
  input  logic [ADDR_W-1:0]                                      base_addr,
  input  logic [1:0]                                             simd_cfg,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   err,
  output logic                                                   mem_rd_en,
  output logic [ADDR_W-1:0]                                      mem_rd_addr,
  input  logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0]                 mem_a,
  input  logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]                   mem_b,
  output logic                                                   ndp_reset,
  output logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0]                 ndp_in_a,
  output logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]                   ndp_in_b,
  output logic                                                   ndp_in_done_flag,
  output logic [1:0]                                             ndp_simd,
  input  logic                                                   ndp_calc_done_flag,
  input  logic [ARR_WIDTH*ARR_HEIGHT*SYS_WIDTH*SYS_HEIGHT*WIDTH-1:0] ndp_out_c,
  output logic [ARR_WIDTH*ARR_HEIGHT*SYS_WIDTH*SYS_HEIGHT*WIDTH-1:0] result,
  output logic                                                   result_valid
);

  localparam int OPA_W = ARR_HEIGHT * SYS_HEIGHT * WIDTH;
  localparam int OPB_W = ARR_WIDTH * SYS_WIDTH * WIDTH;
  localparam int RES_W = ARR_WIDTH * ARR_HEIGHT * SYS_WIDTH * SYS_HEIGHT * WIDTH;

  state_t              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d, rv_q, rv_d;
  logic                rd_en_q, rd_en_d, rd_last_q, rd_last_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, rd_left_q, rd_left_d;
  logic                data_vld_q, data_vld_d, last_vld_q, last_vld_d, in_last_q, in_last_d;
  logic [OPA_W-1:0]    in_a_q, in_a_d;
  logic [OPB_W-1:0]    in_b_q, in_b_d;
  logic                flag_q, flag_d, ndp_reset_q, ndp_reset_d;
  logic [1:0]          simd_q, simd_d;
  logic [RES_W-1:0]    result_q, result_d;

`ifdef NDP_SEQ_TIMEOUT_EN
  logic err_q, err_d, wdog_expired;

  ndp_seq_wdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == S_DRAIN),
    .expired(wdog_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rv_d        = 1'b0;
    rd_en_d     = 1'b0;
    rd_last_d   = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    flag_d      = flag_q;
    ndp_reset_d = 1'b0;
    simd_d      = simd_q;
    result_d    = result_q;
`ifdef NDP_SEQ_TIMEOUT_EN
    err_d       = 1'b0;
`endif
    // Three-stage operand pipe: read strobe -> memory data -> NDPUnit inputs.
    data_vld_d  = rd_en_q;
    last_vld_d  = rd_last_q;
    in_last_d   = last_vld_q;
    in_a_d      = data_vld_q ? mem_a : '0;
    in_b_d      = data_vld_q ? mem_b : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (k_len != '0) begin
            state_d     = S_CLR;
            ndp_reset_d = 1'b1;
            rd_en_d     = 1'b1;
            rd_addr_d   = base_addr;
            rd_left_d   = k_len - 1'b1;
            rd_last_d   = (k_len == ADDR_W'(1));
            simd_d      = simd_cfg;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end
      S_CLR, S_STREAM: begin
        if (state_q == S_CLR) state_d = S_STREAM;
        if (rd_left_q != '0) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rd_left_d = rd_left_q - 1'b1;
          rd_last_d = (rd_left_q == ADDR_W'(1));
        end
        if (in_last_q) begin
          state_d = S_DRAIN;
          flag_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (ndp_calc_done_flag) begin
          state_d  = S_FIN;
          done_d   = 1'b1;
          rv_d     = 1'b1;
          flag_d   = 1'b0;
          result_d = ndp_out_c;
        end
`ifdef NDP_SEQ_TIMEOUT_EN
        else if (wdog_expired) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          flag_d  = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        simd_d  = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rv_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      data_vld_q  <= 1'b0;
      last_vld_q  <= 1'b0;
      in_last_q   <= 1'b0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      flag_q      <= 1'b0;
      ndp_reset_q <= 1'b0;
      simd_q      <= 2'd0;
      result_q    <= '0;
`ifdef NDP_SEQ_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rv_q        <= rv_d;
      rd_en_q     <= rd_en_d;
      rd_last_q   <= rd_last_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      data_vld_q  <= data_vld_d;
      last_vld_q  <= last_vld_d;
      in_last_q   <= in_last_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      flag_q      <= flag_d;
      ndp_reset_q <= ndp_reset_d;
      simd_q      <= simd_d;
      result_q    <= result_d;
`ifdef NDP_SEQ_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign result_valid     = rv_q;
  assign mem_rd_en        = rd_en_q;
  assign mem_rd_addr      = rd_addr_q;
  assign ndp_in_a         = in_a_q;
  assign ndp_in_b         = in_b_q;
  assign ndp_in_done_flag = flag_q;
  assign ndp_simd         = simd_q;
  assign result           = result_q;
  // The NDPUnit is held in reset for as long as the sequencer itself is.
  assign ndp_reset        = ndp_reset_q | reset;
`ifdef NDP_SEQ_TIMEOUT_EN
  assign err              = err_q;
`else
  assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_ndp_seq_ctrl.sv
// tb/tb_ndp_seq_ctrl.sv - scoreboard bench for ndp_seq_ctrl with directed jobs
module tb_ndp_seq_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic        rv;
    logic [63:0] res;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  k_len = 8'd0;
  logic [7:0]  base_addr = 8'd0;
  logic [1:0]  simd_cfg = 2'd0;
  logic        busy, done, err, mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_a = 32'd0;
  logic [31:0] mem_b = 32'd0;
  logic        ndp_reset;
  logic [31:0] ndp_in_a, ndp_in_b;
  logic        ndp_in_done_flag;
  logic [1:0]  ndp_simd;
  logic        ndp_calc_done_flag = 1'b0;
  logic [63:0] ndp_out_c = 64'd0;
  logic [63:0] result;
  logic        result_valid;

  logic [31:0] ma [256];
  logic [31:0] mb [256];
  logic [7:0]  exp_rd [$];
  op_t         exp_op [$];
  int          exp_flag [$];
  done_t       exp_done [$];
  logic [63:0] exp_result = 64'd0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_en = 1'b0;
  logic        prev_flag = 1'b0;

  ndp_seq_ctrl #(
    .WIDTH(16), .ARR_WIDTH(2), .ARR_HEIGHT(2), .SYS_WIDTH(1), .SYS_HEIGHT(1),
    .ADDR_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .base_addr(base_addr),
    .simd_cfg(simd_cfg), .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_a(mem_a), .mem_b(mem_b), .ndp_reset(ndp_reset),
    .ndp_in_a(ndp_in_a), .ndp_in_b(ndp_in_b), .ndp_in_done_flag(ndp_in_done_flag),
    .ndp_simd(ndp_simd), .ndp_calc_done_flag(ndp_calc_done_flag), .ndp_out_c(ndp_out_c),
    .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a <= ma[mem_rd_addr];
      mem_b <= mb[mem_rd_addr];
    end else begin
      mem_a <= 32'hDEAD_BEEF;
      mem_b <= 32'hFEED_F00D;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd_en) begin
        if (exp_rd.size() == 0) check("unexpected_read", 64'(mem_rd_addr) | 64'h100, 64'h0);
        else check("rd_addr", 64'(mem_rd_addr), 64'(exp_rd.pop_front()));
      end
      if (exp_op.size() > 0 && exp_op[0].cyc == cyc) begin
        op_t o;
        o = exp_op.pop_front();
        check("op_a", 64'(ndp_in_a), 64'(o.a));
        check("op_b", 64'(ndp_in_b), 64'(o.b));
      end
      if (ndp_in_done_flag) check("drain_zero_ops", 64'(ndp_in_a | ndp_in_b), 64'h0);
      if (ndp_in_done_flag && !prev_flag) begin
        if (exp_flag.size() == 0) check("unexpected_flag", 64'(ndp_in_done_flag), 64'h0);
        else check("flag_cycle", 64'(cyc), 64'(exp_flag.pop_front()));
      end
      prev_flag <= ndp_in_done_flag;
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 64'(done), 64'h0);
        else begin
          done_t d;
          d = exp_done.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("done_err", 64'(err), 64'(d.err));
          check("done_rv", 64'(result_valid), 64'(d.rv));
          check("done_result", result, d.res);
        end
      end else if (result_valid) check("rv_without_done", 64'(result_valid), 64'h0);
    end
  end

  task automatic goto_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic issue(input logic [7:0] b, input logic [7:0] k, input logic [1:0] s, output int c);
    @(negedge clk);
    c = cyc;
    start = 1'b1; base_addr = b; k_len = k; simd_cfg = s;
    for (int i = 0; i < k; i++) begin
      logic [7:0] ad;
      ad = b + 8'(i);
      exp_rd.push_back(ad);
      exp_op.push_back('{cyc: c + 3 + i, a: ma[ad], b: mb[ad]});
    end
    if (k != 0) exp_flag.push_back(c + 3 + k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_calc(input int t, input logic [63:0] v);
    goto_cyc(t);
    ndp_out_c = v; ndp_calc_done_flag = 1'b1;
    @(negedge clk);
    ndp_calc_done_flag = 1'b0;
  endtask

  task automatic push_done(input int t, input logic e, input logic rv, input logic [63:0] v);
    if (rv) exp_result = v;
    exp_done.push_back('{cyc: t, err: e, rv: rv, res: exp_result});
  endtask

  initial begin
    int c;
    for (int i = 0; i < 256; i++) begin
      ma[i] = 32'hA000_0000 | 32'(i) | 32'h0100;
      mb[i] = 32'hB000_0000 | 32'(i) | 32'h0200;
    end
    ma[0] = 32'h0400_0201; mb[0] = 32'h0403_0201;
    ma[1] = 32'h0803_0402; mb[1] = 32'h0102_0304;

    repeat (3) @(negedge clk);
    check("ndp_reset_in_reset", 64'(ndp_reset), 64'h1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {busy, done, err, mem_rd_en, ndp_in_done_flag, ndp_simd, result_valid, ndp_reset},
          64'h0);
    check("rst_result", result, 64'h0);
    check("rst_ops", 64'({ndp_in_a, ndp_in_b}), 64'h0);
    mon_en = 1'b1;

    // Two-operand job; result 10 cycles after in_done_flag.
    issue(8'h00, 8'd2, 2'd2, c);
    goto_cyc(c + 4);
    check("simd_stream", 64'(ndp_simd), 64'h2);
    push_done(c + 16, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
    pulse_calc(c + 15, 64'h1111_2222_3333_4444);
    goto_cyc(c + 16);
    check("simd_fin", 64'(ndp_simd), 64'h2);
    check("busy_fin", 64'(busy), 64'h1);
    goto_cyc(c + 17);
    check("simd_idle", 64'(ndp_simd), 64'h0);
    check("busy_idle", 64'(busy), 64'h0);

    // Zero-length job finishes without reads or capture.
    issue(8'h05, 8'd0, 2'd1, c);
    push_done(c + 1, 1'b0, 1'b0, 64'h0);
    goto_cyc(c + 3);

    // Address wrap.
    issue(8'hFF, 8'd3, 2'd1, c);
    push_done(c + 9, 1'b0, 1'b1, 64'h5555_6666_7777_8888);
    pulse_calc(c + 8, 64'h5555_6666_7777_8888);
    goto_cyc(c + 11);

    // Reset in the second STREAM cycle.
    begin
      int c0;
      c0 = 0;
      @(negedge clk);
      c0 = cyc;
      start = 1'b1; base_addr = 8'h10; k_len = 8'd4; simd_cfg = 2'd3;
      exp_rd.push_back(8'h10); exp_rd.push_back(8'h11); exp_rd.push_back(8'h12);
      exp_op.push_back('{cyc: c0 + 3, a: ma[8'h10], b: mb[8'h10]});
      @(negedge clk);
      start = 1'b0;
      goto_cyc(c0 + 3);
      reset = 1'b1;
      #1 check("ndp_reset_mid", 64'(ndp_reset), 64'h1);
      goto_cyc(c0 + 4);
      check("midrst_outputs", {busy, done, err, mem_rd_en, ndp_in_done_flag, ndp_simd, result_valid}, 64'h0);
      check("midrst_result", result, 64'h0);
      check("midrst_ops", 64'({ndp_in_a, ndp_in_b}), 64'h0);
      exp_result = 64'h0;
      reset = 1'b0;
    end
    issue(8'h20, 8'd1, 2'd1, c);
    push_done(c + 7, 1'b0, 1'b1, 64'h0BAD_CAFE_0000_0001);
    pulse_calc(c + 6, 64'h0BAD_CAFE_0000_0001);
    goto_cyc(c + 9);

    // calc_done during STREAM and start during DRAIN are ignored.
    issue(8'h30, 8'd2, 2'd1, c);
    ndp_out_c = 64'hFFFF_0000_FFFF_0000; ndp_calc_done_flag = 1'b1;
    goto_cyc(c + 5);
    ndp_calc_done_flag = 1'b0;
    goto_cyc(c + 6);
    start = 1'b1; k_len = 8'd5; base_addr = 8'h50;
    @(negedge clk);
    start = 1'b0;
    push_done(c + 10, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    pulse_calc(c + 9, 64'h1234_5678_9ABC_DEF0);
    goto_cyc(c + 12);

`ifdef NDP_SEQ_TIMEOUT_EN
    issue(8'h40, 8'd1, 2'd1, c);
    push_done(c + 20, 1'b1, 1'b0, 64'h0);
    goto_cyc(c + 22);
    issue(8'h41, 8'd1, 2'd1, c);
    push_done(c + 20, 1'b0, 1'b1, 64'hC0DE_0000_0000_0042);
    pulse_calc(c + 19, 64'hC0DE_0000_0000_0042);
    goto_cyc(c + 22);
`endif

    begin
      int guard = 0;
      while ((exp_rd.size() + exp_op.size() + exp_flag.size() + exp_done.size()) != 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    check("left_reads", 64'(exp_rd.size()), 64'h0);
    check("left_ops", 64'(exp_op.size()), 64'h0);
    check("left_flags", 64'(exp_flag.size()), 64'h0);
    check("left_dones", 64'(exp_done.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
